aes_core_sequencer: RTL and testbench

AES_CORE_SEQUENCER -- requirements
Module: aes_core_sequencer

---
 rtl/aes_core_sequencer.sv | 174 +++++++++++++++++
 tb/tb_aes_core_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_core_sequencer.sv
// Job sequencer in front of AES-128 key-expansion, encrypt and decrypt cores:
// accepts one job, optionally loads the key, starts the right core, waits for it, returns the result.
module aes_core_sequencer #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_mode,
    input  logic         in_new_key,
    input  logic [127:0] in_key,
    input  logic [127:0] in_data,
    output logic         set_new_key,
    output logic [127:0] key_in,
    output logic         start_enc,
    output logic         start_dec,
    output logic [127:0] plain_text_o,
    output logic [127:0] cipher_text_o,
    input  logic         done_enc,
    input  logic         done_dec,
    input  logic [127:0] cipher_text_i,
    input  logic [127:0] plain_text_i,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         out_mode,
    output logic         out_timeout,
    output logic [2:0]   dbg_state
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD_KEY  = 3'd1,
        S_START     = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_OUTPUT    = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic               mode_q, mode_d;
    logic [127:0]       key_in_q, key_in_d;
    logic [127:0]       pt_q, pt_d;
    logic [127:0]       ct_q, ct_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_enc_prev_q, done_enc_prev_d;
    logic               done_dec_prev_q, done_dec_prev_d;
    logic [127:0]       out_data_q, out_data_d;
    logic               out_mode_q, out_mode_d;
    logic               out_timeout_q, out_timeout_d;

    logic               sel_done;
    logic               sel_prev;
    logic               done_edge;

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // in_ready is high only in IDLE, and the result is held until out_ready.
    assign in_ready      = (state_q == S_IDLE);
    assign set_new_key   = (state_q == S_LOAD_KEY);
    assign start_enc     = (state_q == S_START) && !mode_q;
    assign start_dec     = (state_q == S_START) && mode_q;
    assign out_valid     = (state_q == S_OUTPUT);
    assign key_in        = key_in_q;
    assign plain_text_o  = pt_q;
    assign cipher_text_o = ct_q;
    assign out_data      = out_data_q;
    assign out_mode      = out_mode_q;
    assign out_timeout   = out_timeout_q;
    assign dbg_state     = state_q;

    // Only the core selected by the job's mode can complete it, and only on a fresh 0->1 edge.
    assign sel_done  = mode_q ? done_dec : done_enc;
    assign sel_prev  = mode_q ? done_dec_prev_q : done_enc_prev_q;
    assign done_edge = sel_done && !sel_prev;

    always_comb begin
        state_d         = state_q;
        mode_d          = mode_q;
        key_in_d        = key_in_q;
        pt_d            = pt_q;
        ct_d            = ct_q;
        cnt_d           = cnt_q;
        done_enc_prev_d = done_enc;
        done_dec_prev_d = done_dec;
        out_data_d      = out_data_q;
        out_mode_d      = out_mode_q;
        out_timeout_d   = out_timeout_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    mode_d = in_mode;
                    // Only the operand bus of this job's core changes; the other keeps its value.
                    if (in_mode) begin
                        ct_d = in_data;
                    end else begin
                        pt_d = in_data;
                    end
                    if (in_new_key) begin
                        key_in_d = in_key;
                        state_d  = S_LOAD_KEY;
                    end else begin
                        state_d  = S_START;
                    end
                end
            end
            S_LOAD_KEY: begin
                state_d = S_START;
            end
            S_START: begin
                cnt_d   = '0;
                state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
                // A done edge in the final timeout cycle still delivers a real result.
                if (done_edge) begin
                    out_data_d    = mode_q ? plain_text_i : cipher_text_i;
                    out_mode_d    = mode_q;
                    out_timeout_d = 1'b0;
                    state_d       = S_OUTPUT;
                end else if (cnt_q >= CNT_LAST) begin
                    out_data_d    = '0;
                    out_mode_d    = mode_q;
                    out_timeout_d = 1'b1;
                    state_d       = S_OUTPUT;
                end
            end
            S_OUTPUT: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            mode_q          <= 1'b0;
            key_in_q        <= '0;
            pt_q            <= '0;
            ct_q            <= '0;
            cnt_q           <= '0;
            done_enc_prev_q <= 1'b0;
            done_dec_prev_q <= 1'b0;
            out_data_q      <= '0;
            out_mode_q      <= 1'b0;
            out_timeout_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            mode_q          <= mode_d;
            key_in_q        <= key_in_d;
            pt_q            <= pt_d;
            ct_q            <= ct_d;
            cnt_q           <= cnt_d;
            done_enc_prev_q <= done_enc_prev_d;
            done_dec_prev_q <= done_dec_prev_d;
            out_data_q      <= out_data_d;
            out_mode_q      <= out_mode_d;
            out_timeout_q   <= out_timeout_d;
        end
    end

endmodule

// File: tb/tb_aes_core_sequencer.sv
// Bench for aes_core_sequencer: directed jobs against a job-level reference model,
// compared every cycle, plus literal results for the known AES vectors and boundaries.
module tb_aes_core_sequencer;

    localparam int TO = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         in_mode = 1'b0;
    logic         in_new_key = 1'b0;
    logic [127:0] in_key = '0;
    logic [127:0] in_data = '0;
    logic         set_new_key;
    logic [127:0] key_in;
    logic         start_enc;
    logic         start_dec;
    logic [127:0] plain_text_o;
    logic [127:0] cipher_text_o;
    logic         done_enc = 1'b0;
    logic         done_dec = 1'b0;
    logic [127:0] cipher_text_i = '0;
    logic [127:0] plain_text_i = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_data;
    logic         out_mode;
    logic         out_timeout;
    logic [2:0]   dbg_state;

    aes_core_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .in_new_key(in_new_key), .in_key(in_key), .in_data(in_data),
        .set_new_key(set_new_key), .key_in(key_in),
        .start_enc(start_enc), .start_dec(start_dec),
        .plain_text_o(plain_text_o), .cipher_text_o(cipher_text_o),
        .done_enc(done_enc), .done_dec(done_dec),
        .cipher_text_i(cipher_text_i), .plain_text_i(plain_text_i),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_mode(out_mode), .out_timeout(out_timeout), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    // control shared from the main sequence to the checker (written only by main)
    bit chk_en = 1'b0;
    bit rst_pin = 1'b0;
    int test_id = 0;
    int n_expired = 0;

    // checker bookkeeping (written only by the compare process)
    int n_cmp = 0;
    int n_fail = 0;
    int n_exp_seen = 0;
    int cyc = 0;
    int start_cyc = 0;
    bit ov_prev = 1'b0;

    // job-level reference model
    bit           m_busy = 1'b0;
    bit           m_have = 1'b0;
    bit           m_mode = 1'b0;
    bit           m_nk = 1'b0;
    bit           m_edge = 1'b0;
    int           m_age = 0;
    int           m_wait = 0;
    logic [127:0] m_key = '0;
    logic [127:0] m_pt = '0;
    logic [127:0] m_ct = '0;
    logic [127:0] m_res_data = '0;
    bit           m_res_mode = 1'b0;
    bit           m_res_to = 1'b0;
    bit           m_prev_enc = 1'b0;
    bit           m_prev_dec = 1'b0;

    initial forever begin
        @(posedge clk);
        if (reset) begin
            m_busy = 0; m_have = 0; m_age = 0; m_wait = 0; m_mode = 0; m_nk = 0;
            m_key = '0; m_pt = '0; m_ct = '0;
            m_res_data = '0; m_res_mode = 0; m_res_to = 0;
            m_prev_enc = 0; m_prev_dec = 0;
        end else begin
            m_edge = m_mode ? (done_dec && !m_prev_dec) : (done_enc && !m_prev_enc);
            if (!m_busy) begin
                if (in_valid) begin
                    m_busy = 1; m_age = 1; m_wait = 0;
                    m_mode = in_mode; m_nk = in_new_key;
                    if (in_new_key) m_key = in_key;
                    if (in_mode) m_ct = in_data;
                    else m_pt = in_data;
                end
            end else if (m_have) begin
                if (out_ready) begin
                    m_busy = 0; m_have = 0;
                end
            end else if (m_age > 1 + int'(m_nk)) begin
                m_wait++;
                if (m_edge) begin
                    m_have = 1; m_res_mode = m_mode; m_res_to = 0;
                    m_res_data = m_mode ? plain_text_i : cipher_text_i;
                end else if (m_wait == TO) begin
                    m_have = 1; m_res_mode = m_mode; m_res_to = 1; m_res_data = '0;
                end
            end else begin
                m_age++;
            end
            m_prev_enc = done_enc;
            m_prev_dec = done_dec;
        end
    end

    // scoreboard compare
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial forever begin
        @(negedge clk);
        cyc++;
        if (chk_en) begin
            bit e_start;
            bit e_run;
            e_start = m_busy && !m_have && (m_age == 1 + int'(m_nk));
            e_run   = m_busy && !m_have && (m_age >= 1 + int'(m_nk));
            chk("wait_bound", 128'(n_expired), 128'(n_exp_seen));
            n_exp_seen = n_expired;
            chk("in_ready", 128'(in_ready), 128'(!m_busy));
            chk("set_new_key", 128'(set_new_key), 128'(m_busy && !m_have && m_nk && m_age == 1));
            chk("start_enc", 128'(start_enc), 128'(e_start && !m_mode));
            chk("start_dec", 128'(start_dec), 128'(e_start && m_mode));
            chk("out_valid", 128'(out_valid), 128'(m_have));
            chk("key_in", key_in, m_key);
            if (e_run) begin
                chk("plain_text_o", plain_text_o, m_pt);
                chk("cipher_text_o", cipher_text_o, m_ct);
            end
            if (m_have) begin
                chk("out_data", out_data, m_res_data);
                chk("out_mode", 128'(out_mode), 128'(m_res_mode));
                chk("out_timeout", 128'(out_timeout), 128'(m_res_to));
            end
            if (rst_pin) begin
                chk("rst_in_ready", 128'(in_ready), 128'(1));
                chk("rst_strobes", 128'({set_new_key, start_enc, start_dec, out_valid}), 128'(0));
                chk("rst_key_in", key_in, 128'(0));
                chk("rst_pt", plain_text_o, 128'(0));
                chk("rst_ct", cipher_text_o, 128'(0));
                chk("rst_out", {out_data[125:0], out_mode, out_timeout}, 128'(0));
            end
            if (start_enc || start_dec) start_cyc = cyc;
            if (out_valid && !ov_prev) begin
                case (test_id)
                    1: begin
                        chk("t1_data", out_data, 128'h3925841d02dc09fbdc118597196a0b32);
                        chk("t1_mode_to", 128'({out_mode, out_timeout}), 128'(0));
                    end
                    2: begin
                        chk("t2_data", out_data, 128'h3243f6a8885a308d313198a2e0370734);
                        chk("t2_mode_to", 128'({out_mode, out_timeout}), 128'(2));
                    end
                    4: begin
                        chk("t4_data", out_data, 128'(0));
                        chk("t4_timeout", 128'(out_timeout), 128'(1));
                        chk("t4_latency", 128'(cyc - start_cyc), 128'(TO + 1));
                    end
                    5: begin
                        chk("t5_data", out_data, 128'h00112233445566778899aabbccddeeff);
                        chk("t5_timeout", 128'(out_timeout), 128'(0));
                    end
                    6: chk("t6_data", out_data, 128'h0f0e0d0c0b0a09080706050403020100);
                    7: chk("t7_data", out_data, 128'h1234567890abcdef1234567890abcdef);
                    default: ;
                endcase
            end
            ov_prev = out_valid;
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept_job(input bit mode, input bit nk, input logic [127:0] key,
                              input logic [127:0] data);
        for (int i = 0; i < 50 && !in_ready; i++) step();
        if (!in_ready) n_expired++;
        in_valid = 1; in_mode = mode; in_new_key = nk; in_key = key; in_data = data;
        step();
        in_valid = 0; in_mode = !mode; in_new_key = !nk; in_key = ~key; in_data = ~data;
    endtask

    task automatic wait_start();
        for (int i = 0; i < 5 && !(start_enc || start_dec); i++) step();
        if (!(start_enc || start_dec)) n_expired++;
    endtask

    // Raise the selected core's done in the lat-th WAIT_DONE cycle, decoy on the other bus.
    task automatic core_done(input bit mode, input int lat, input logic [127:0] res);
        repeat (lat) step();
        if (mode) begin
            done_dec = 1; plain_text_i = res; cipher_text_i = ~res;
        end else begin
            done_enc = 1; cipher_text_i = res; plain_text_i = ~res;
        end
        step();
        done_enc = 0; done_dec = 0;
    endtask

    task automatic finish_out(input int hold);
        for (int i = 0; i < 40 && !out_valid; i++) step();
        if (!out_valid) n_expired++;
        if (hold > 0) begin
            in_valid = 1; in_mode = 1; in_new_key = 1;
            in_data = 128'(2 * $urandom_range(1, 1000)); in_key = 128'($urandom_range(1, 1000));
            repeat (hold) step();
            in_valid = 0;
        end
        out_ready = 1;
        step();
        out_ready = 0;
    endtask

    task automatic run_job(input int tid, input bit mode, input bit nk, input logic [127:0] key,
                           input logic [127:0] data, input int lat, input logic [127:0] res,
                           input int hold);
        test_id = tid;
        accept_job(mode, nk, key, data);
        wait_start();
        if (lat > 0) core_done(mode, lat, res);
        finish_out(hold);
    endtask

    // global guard
    initial begin
        #200000;
        $display("FAIL global_time_limit: got no summary expected summary before 200000");
        $fatal(1);
    end

    initial begin
        step();
        chk_en = 1; rst_pin = 1;
        step();
        reset = 0; rst_pin = 0;
        step();

        run_job(1, 0, 1, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                128'h3243f6a8885a308d313198a2e0370734, 3,
                128'h3925841d02dc09fbdc118597196a0b32, 0);
        run_job(2, 1, 0, 128'h0, 128'h3925841d02dc09fbdc118597196a0b32, 5,
                128'h3243f6a8885a308d313198a2e0370734, 0);
        run_job(3, 0, 0, 128'h0, 128'h00112233445566778899aabbccddeeff, 2,
                128'h69c4e0d86a7b0430d8cdb78070b4c55a, 10);
        run_job(4, 0, 0, 128'h0, 128'hdeadbeefdeadbeefdeadbeefdeadbeef, 0, 128'h0, 0);
        run_job(5, 1, 1, 128'h000102030405060708090a0b0c0d0e0f,
                128'h69c4e0d86a7b0430d8cdb78070b4c55a, TO,
                128'h00112233445566778899aabbccddeeff, 0);

        // wrong-core done is ignored, then the enc core completes
        test_id = 6;
        accept_job(0, 0, 128'h0, 128'h55555555aaaaaaaa55555555aaaaaaaa);
        wait_start();
        step();
        done_dec = 1; plain_text_i = 128'hffffffffffffffffffffffffffffffff;
        step();
        done_dec = 0;
        core_done(0, 3, 128'h0f0e0d0c0b0a09080706050403020100);
        finish_out(0);

        // done already high on entry must fall and rise again
        test_id = 7;
        done_enc = 1; cipher_text_i = 128'hbad0bad0bad0bad0bad0bad0bad0bad0;
        accept_job(0, 0, 128'h0, 128'h11111111222222223333333344444444);
        wait_start();
        repeat (3) step();
        done_enc = 0;
        core_done(0, 1, 128'h1234567890abcdef1234567890abcdef);
        finish_out(0);

        // reset in the middle of WAIT_DONE discards the job
        test_id = 8;
        accept_job(0, 1, 128'hcafef00dcafef00dcafef00dcafef00d, 128'h0123456789abcdef0123456789abcdef);
        wait_start();
        repeat (2) step();
        reset = 1;
        step();
        reset = 0; rst_pin = 1;
        step();
        rst_pin = 0;
        core_done(0, 1, 128'h77777777777777777777777777777777);
        repeat (5) step();

        run_job(9, 0, 0, 128'h0, 128'h89abcdef89abcdef89abcdef89abcdef, 4,
                128'hfedcba9876543210fedcba9876543210, 2);

        repeat (3) step();
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_cmp, n_fail);
        $finish;
    end

endmodule
